// File: rtl/peripheral_arbiter.sv
// Round-robin arbiter sharing one peripheral port between NUM_CORES cores, one transaction at a time.
// Optional read-response watchdog enabled by defining ARB_TIMEOUT_EN.
module peripheral_arbiter #(
   parameter int NUM_CORES      = 4,
   parameter int DATA_WIDTH     = 32,
   parameter int ID_BITS        = 2,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic [2*NUM_CORES-1:0]           core_to_peripheral,
   input  logic [DATA_WIDTH*NUM_CORES-1:0]  core_to_peripheral_data,
   input  logic [NUM_CORES-1:0]             core_to_peripheral_valid,
   output logic [2*NUM_CORES-1:0]           core_from_peripheral,
   output logic [DATA_WIDTH*NUM_CORES-1:0]  core_from_peripheral_data,
   output logic [NUM_CORES-1:0]             core_from_peripheral_valid,
   output logic                             periph_req_valid,
   output logic [1:0]                       periph_req_cmd,
   output logic [DATA_WIDTH-1:0]            periph_req_data,
   output logic [ID_BITS-1:0]               periph_req_id,
   input  logic                             periph_req_ready,
   input  logic                             periph_resp_valid,
   input  logic [DATA_WIDTH-1:0]            periph_resp_data,
   output logic [NUM_CORES-1:0]             overflow,
   output logic                             timeout_err,
   output logic [1:0]                       dbg_state,
   output logic [ID_BITS-1:0]               dbg_rr_ptr
);

   if (NUM_CORES < 2 || NUM_CORES > 16) begin : g_bad_num_cores
      $error("NUM_CORES must be in 2..16");
   end
   if ((1 << ID_BITS) < NUM_CORES) begin : g_bad_id_bits
      $error("ID_BITS too narrow for NUM_CORES");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_ISSUE     = 2'd1,
      S_WAIT_RESP = 2'd2
   } state_t;

   state_t                  state;
   logic [ID_BITS-1:0]      rr_ptr;
   logic [NUM_CORES-1:0]    pending;
   logic [NUM_CORES-1:0]    req_live;
   logic [NUM_CORES-1:0]    slot_clear;
   logic [1:0]              req_cmd   [NUM_CORES];
   logic [DATA_WIDTH-1:0]   req_data  [NUM_CORES];
   logic [1:0]              slot_cmd  [NUM_CORES];
   logic [DATA_WIDTH-1:0]   slot_data [NUM_CORES];
   logic [1:0]              resp_cmd  [NUM_CORES];
   logic [DATA_WIDTH-1:0]   resp_data [NUM_CORES];
   logic                    sel_found;
   logic [ID_BITS-1:0]      sel_idx;
   int                      scan_idx;

`ifdef ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [DATA_WIDTH-1:0] TIMEOUT_DATA = DATA_WIDTH'(32'hDEAD_BEEF);
   logic [CNT_W-1:0] wait_cnt;
`else
   assign timeout_err = 1'b0;
`endif

   assign dbg_state  = state;
   assign dbg_rr_ptr = rr_ptr;

   // A slot being granted this edge counts as empty, so a new strobe refills it.
   always_comb begin
      req_live   = '0;
      slot_clear = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         req_cmd[i]    = core_to_peripheral[2*i +: 2];
         req_data[i]   = core_to_peripheral_data[DATA_WIDTH*i +: DATA_WIDTH];
         req_live[i]   = core_to_peripheral_valid[i] && (req_cmd[i] != 2'b00);
         slot_clear[i] = (state == S_ISSUE) && periph_req_ready &&
                         (periph_req_id == ID_BITS'(i));
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pending  <= '0;
         overflow <= '0;
         for (int i = 0; i < NUM_CORES; i++) begin
            slot_cmd[i]  <= 2'b00;
            slot_data[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_CORES; i++) begin
            if (req_live[i]) begin
               if (!pending[i] || slot_clear[i]) begin
                  pending[i]   <= 1'b1;
                  slot_cmd[i]  <= req_cmd[i];
                  slot_data[i] <= req_data[i];
               end else begin
                  overflow[i] <= 1'b1;
               end
            end else if (slot_clear[i]) begin
               pending[i] <= 1'b0;
            end
         end
      end
   end

   // Scan downward so the smallest offset from rr_ptr wins.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      scan_idx  = 0;
      for (int k = NUM_CORES - 1; k >= 0; k--) begin
         scan_idx = int'(rr_ptr) + k;
         if (scan_idx >= NUM_CORES) scan_idx = scan_idx - NUM_CORES;
         if (pending[scan_idx]) begin
            sel_found = 1'b1;
            sel_idx   = ID_BITS'(scan_idx);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state                      <= S_IDLE;
         rr_ptr                     <= '0;
         periph_req_valid           <= 1'b0;
         periph_req_cmd             <= 2'b00;
         periph_req_data            <= '0;
         periph_req_id              <= '0;
         core_from_peripheral_valid <= '0;
         for (int i = 0; i < NUM_CORES; i++) begin
            resp_cmd[i]  <= 2'b00;
            resp_data[i] <= '0;
         end
`ifdef ARB_TIMEOUT_EN
         wait_cnt    <= '0;
         timeout_err <= 1'b0;
`endif
      end else begin
         core_from_peripheral_valid <= '0;
         case (state)
            S_IDLE: begin
               if (sel_found) begin
                  periph_req_valid <= 1'b1;
                  periph_req_cmd   <= slot_cmd[sel_idx];
                  periph_req_data  <= slot_data[sel_idx];
                  periph_req_id    <= sel_idx;
                  state            <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (periph_req_ready) begin
                  periph_req_valid <= 1'b0;
                  rr_ptr <= (periph_req_id == ID_BITS'(NUM_CORES - 1)) ?
                            '0 : periph_req_id + ID_BITS'(1);
                  // Writes are posted; only reads wait for a response.
                  state  <= periph_req_cmd[1] ? S_WAIT_RESP : S_IDLE;
`ifdef ARB_TIMEOUT_EN
                  wait_cnt <= '0;
`endif
               end
            end
            S_WAIT_RESP: begin
               if (periph_resp_valid) begin
                  core_from_peripheral_valid[periph_req_id] <= 1'b1;
                  resp_data[periph_req_id] <= periph_resp_data;
                  resp_cmd[periph_req_id]  <= periph_req_cmd;
                  state <= S_IDLE;
`ifdef ARB_TIMEOUT_EN
               end else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  core_from_peripheral_valid[periph_req_id] <= 1'b1;
                  resp_data[periph_req_id] <= TIMEOUT_DATA;
                  resp_cmd[periph_req_id]  <= periph_req_cmd;
                  timeout_err <= 1'b1;
                  state       <= S_IDLE;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
`endif
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      core_from_peripheral      = '0;
      core_from_peripheral_data = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         core_from_peripheral[2*i +: 2]                   = resp_cmd[i];
         core_from_peripheral_data[DATA_WIDTH*i +: DATA_WIDTH] = resp_data[i];
      end
   end

endmodule

// File: tb/tb_peripheral_arbiter.sv
// Bench for peripheral_arbiter: directed scenarios plus a randomized run against a request/response model.
module tb_peripheral_arbiter;
   localparam int NC = 4;
   localparam int DW = 32;
   localparam int IB = 2;
   localparam int TO = 8;

   logic              clock = 1'b0;
   logic              reset;
   logic [2*NC-1:0]   core_to_peripheral;
   logic [DW*NC-1:0]  core_to_peripheral_data;
   logic [NC-1:0]     core_to_peripheral_valid;
   logic [2*NC-1:0]   core_from_peripheral;
   logic [DW*NC-1:0]  core_from_peripheral_data;
   logic [NC-1:0]     core_from_peripheral_valid;
   logic              periph_req_valid;
   logic [1:0]        periph_req_cmd;
   logic [DW-1:0]     periph_req_data;
   logic [IB-1:0]     periph_req_id;
   logic              periph_req_ready;
   logic              periph_resp_valid;
   logic [DW-1:0]     periph_resp_data;
   logic [NC-1:0]     overflow;
   logic              timeout_err;
   logic [1:0]        dbg_state;
   logic [IB-1:0]     dbg_rr_ptr;

   int checks   = 0;
   int failures = 0;
   logic [IB+DW-1:0] exp_q[$];

   peripheral_arbiter #(
      .NUM_CORES(NC), .DATA_WIDTH(DW), .ID_BITS(IB), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clock(clock), .reset(reset),
      .core_to_peripheral(core_to_peripheral),
      .core_to_peripheral_data(core_to_peripheral_data),
      .core_to_peripheral_valid(core_to_peripheral_valid),
      .core_from_peripheral(core_from_peripheral),
      .core_from_peripheral_data(core_from_peripheral_data),
      .core_from_peripheral_valid(core_from_peripheral_valid),
      .periph_req_valid(periph_req_valid), .periph_req_cmd(periph_req_cmd),
      .periph_req_data(periph_req_data), .periph_req_id(periph_req_id),
      .periph_req_ready(periph_req_ready),
      .periph_resp_valid(periph_resp_valid), .periph_resp_data(periph_resp_data),
      .overflow(overflow), .timeout_err(timeout_err),
      .dbg_state(dbg_state), .dbg_rr_ptr(dbg_rr_ptr)
   );

   // clock / reset
   always #5 clock = ~clock;

   initial begin
      #1000000;
      $display("FAIL global_time_limit got=expired exp=finish");
      $fatal(1, "time limit");
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic drive_req(input int core, input logic [1:0] cmd, input logic [DW-1:0] data);
      core_to_peripheral[2*core +: 2]        = cmd;
      core_to_peripheral_data[DW*core +: DW] = data;
      core_to_peripheral_valid[core]         = 1'b1;
   endtask

   task automatic clear_reqs();
      core_to_peripheral_valid = '0;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      clear_reqs();
      periph_req_ready  = 1'b0;
      periph_resp_valid = 1'b0;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      checks++; if (periph_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got=%0h exp=0", periph_req_valid); end
      checks++; if (core_from_peripheral_valid !== 4'h0) begin failures++; $display("FAIL reset_resp_valid got=%0h exp=0", core_from_peripheral_valid); end
      checks++; if (overflow !== 4'h0) begin failures++; $display("FAIL reset_overflow got=%0h exp=0", overflow); end
      checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL reset_timeout_err got=%0h exp=0", timeout_err); end
      checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
      checks++; if (dbg_rr_ptr !== 2'd0) begin failures++; $display("FAIL reset_rr_ptr got=%0d exp=0", dbg_rr_ptr); end
      checks++; if ({periph_req_cmd, periph_req_data, periph_req_id} !== '0) begin failures++; $display("FAIL reset_req_fields got=%0h exp=0", {periph_req_cmd, periph_req_data, periph_req_id}); end
      checks++; if ({core_from_peripheral, core_from_peripheral_data} !== '0) begin failures++; $display("FAIL reset_resp_fields got=%0h exp=0", {core_from_peripheral, core_from_peripheral_data}); end
   endtask

   task automatic test_single_write();
      periph_req_ready = 1'b1;
      drive_req(1, 2'b01, 32'h55);
      step();
      clear_reqs();
      checks++; if (periph_req_valid !== 1'b0) begin failures++; $display("FAIL wr_not_early got=%0h exp=0", periph_req_valid); end
      step();
      checks++; if (periph_req_valid !== 1'b1) begin failures++; $display("FAIL wr_req_valid got=%0h exp=1", periph_req_valid); end
      checks++; if (periph_req_id !== 2'd1) begin failures++; $display("FAIL wr_req_id got=%0d exp=1", periph_req_id); end
      checks++; if (periph_req_data !== 32'h55) begin failures++; $display("FAIL wr_req_data got=%0h exp=55", periph_req_data); end
      checks++; if (periph_req_cmd !== 2'b01) begin failures++; $display("FAIL wr_req_cmd got=%0b exp=01", periph_req_cmd); end
      step();
      checks++; if (periph_req_valid !== 1'b0) begin failures++; $display("FAIL wr_req_drop got=%0h exp=0", periph_req_valid); end
      checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL wr_back_idle got=%0d exp=0", dbg_state); end
      step();
      checks++; if (core_from_peripheral_valid !== 4'h0) begin failures++; $display("FAIL wr_no_resp got=%0h exp=0", core_from_peripheral_valid); end
   endtask

   task automatic test_single_read();
      periph_req_ready = 1'b1;
      drive_req(2, 2'b10, 32'h10);
      step();
      clear_reqs();
      step();
      checks++; if ({periph_req_valid, periph_req_id, periph_req_cmd, periph_req_data} !== {1'b1, 2'd2, 2'b10, 32'h10}) begin failures++; $display("FAIL rd_req got=%0h exp=%0h", {periph_req_valid, periph_req_id, periph_req_cmd, periph_req_data}, {1'b1, 2'd2, 2'b10, 32'h10}); end
      step();
      checks++; if (dbg_state !== 2'd2) begin failures++; $display("FAIL rd_wait_state got=%0d exp=2", dbg_state); end
      for (int k = 0; k < 2; k++) begin
         step();
         checks++; if (core_from_peripheral_valid !== 4'h0) begin failures++; $display("FAIL rd_early_resp got=%0h exp=0", core_from_peripheral_valid); end
      end
      periph_resp_valid = 1'b1;
      periph_resp_data  = 32'hCAFE0001;
      step();
      periph_resp_valid = 1'b0;
      periph_resp_data  = 32'h0;
      checks++; if (core_from_peripheral_valid !== 4'b0100) begin failures++; $display("FAIL rd_resp_valid got=%0h exp=4", core_from_peripheral_valid); end
      checks++; if (core_from_peripheral_data[DW*2 +: DW] !== 32'hCAFE0001) begin failures++; $display("FAIL rd_resp_data got=%0h exp=cafe0001", core_from_peripheral_data[DW*2 +: DW]); end
      checks++; if (core_from_peripheral[5:4] !== 2'b10) begin failures++; $display("FAIL rd_resp_cmd got=%0b exp=10", core_from_peripheral[5:4]); end
      step();
      checks++; if (core_from_peripheral_valid !== 4'h0) begin failures++; $display("FAIL rd_resp_one_cycle got=%0h exp=0", core_from_peripheral_valid); end
      checks++; if (core_from_peripheral_data[DW*2 +: DW] !== 32'hCAFE0001) begin failures++; $display("FAIL rd_resp_hold got=%0h exp=cafe0001", core_from_peripheral_data[DW*2 +: DW]); end
      checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL rd_back_idle got=%0d exp=0", dbg_state); end
   endtask

   task automatic test_round_robin();
      int   cyc;
      int   last_cyc;
      logic sent_fresh;
      apply_reset();
      periph_req_ready = 1'b1;
      for (int i = 0; i < NC; i++) drive_req(i, 2'b01, 32'hA0 + i);
      for (int i = 0; i < NC; i++) exp_q.push_back({IB'(i), DW'(32'hA0 + i)});
      exp_q.push_back({2'd0, 32'hB0});
      step();
      clear_reqs();
      cyc = 0;
      last_cyc = -1;
      sent_fresh = 1'b0;
      while (exp_q.size() > 0 && cyc < 40) begin
         if (periph_req_valid) begin
            checks++; if ({periph_req_id, periph_req_data} !== exp_q[0]) begin failures++; $display("FAIL rr_order got=%0h exp=%0h", {periph_req_id, periph_req_data}, exp_q[0]); end
            if (last_cyc >= 0) begin
               checks++; if (cyc - last_cyc !== 2) begin failures++; $display("FAIL rr_spacing got=%0d exp=2", cyc - last_cyc); end
            end
            if (periph_req_id == 2'd1 && !sent_fresh) begin
               drive_req(0, 2'b01, 32'hB0);
               sent_fresh = 1'b1;
            end
            last_cyc = cyc;
            void'(exp_q.pop_front());
         end
         step();
         clear_reqs();
         cyc++;
      end
      checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL rr_budget got=%0d exp=0 grants left", exp_q.size()); end
      exp_q.delete();
   endtask

   task automatic test_overflow();
      periph_req_ready = 1'b0;
      drive_req(0, 2'b01, 32'h11);
      step();
      drive_req(0, 2'b01, 32'h22);
      step();
      clear_reqs();
      checks++; if (overflow !== 4'b0001) begin failures++; $display("FAIL ovf_flag got=%0h exp=1", overflow); end
      checks++; if ({periph_req_valid, periph_req_id, periph_req_data} !== {1'b1, 2'd0, 32'h11}) begin failures++; $display("FAIL ovf_first_kept got=%0h exp=%0h", {periph_req_valid, periph_req_id, periph_req_data}, {1'b1, 2'd0, 32'h11}); end
      step();
      step();
      checks++; if ({periph_req_valid, periph_req_data} !== {1'b1, 32'h11}) begin failures++; $display("FAIL ovf_hold got=%0h exp=%0h", {periph_req_valid, periph_req_data}, {1'b1, 32'h11}); end
      periph_req_ready = 1'b1;
      drive_req(0, 2'b01, 32'h33);
      step();
      clear_reqs();
      checks++; if (periph_req_valid !== 1'b0) begin failures++; $display("FAIL ovf_accept got=%0h exp=0", periph_req_valid); end
      checks++; if (overflow !== 4'b0001) begin failures++; $display("FAIL ovf_reuse_no_flag got=%0h exp=1", overflow); end
      step();
      checks++; if ({periph_req_valid, periph_req_id, periph_req_data} !== {1'b1, 2'd0, 32'h33}) begin failures++; $display("FAIL ovf_reuse_issue got=%0h exp=%0h", {periph_req_valid, periph_req_id, periph_req_data}, {1'b1, 2'd0, 32'h33}); end
      step();
      checks++; if ({periph_req_valid, overflow} !== {1'b0, 4'b0001}) begin failures++; $display("FAIL ovf_sticky got=%0h exp=%0h", {periph_req_valid, overflow}, {1'b0, 4'b0001}); end
   endtask

   task automatic test_reset_mid_read();
      periph_req_ready = 1'b1;
      drive_req(2, 2'b10, 32'h20);
      step();
      clear_reqs();
      step();
      step();
      checks++; if ({dbg_state, dbg_rr_ptr} !== {2'd2, 2'd3}) begin failures++; $display("FAIL mid_pre_state got=%0h exp=%0h", {dbg_state, dbg_rr_ptr}, {2'd2, 2'd3}); end
      reset = 1'b1;
      step();
      reset = 1'b0;
      periph_req_ready = 1'b0;
      checks++; if ({periph_req_valid, periph_req_cmd, periph_req_data, periph_req_id} !== '0) begin failures++; $display("FAIL mid_req_cleared got=%0h exp=0", {periph_req_valid, periph_req_cmd, periph_req_data, periph_req_id}); end
      checks++; if ({dbg_state, dbg_rr_ptr, overflow, timeout_err} !== '0) begin failures++; $display("FAIL mid_ctrl_cleared got=%0h exp=0", {dbg_state, dbg_rr_ptr, overflow, timeout_err}); end
      periph_resp_valid = 1'b1;
      periph_resp_data  = 32'h1234;
      step();
      periph_resp_valid = 1'b0;
      checks++; if (core_from_peripheral_valid !== 4'h0) begin failures++; $display("FAIL mid_stale_resp got=%0h exp=0", core_from_peripheral_valid); end
      checks++; if ({core_from_peripheral, core_from_peripheral_data} !== '0) begin failures++; $display("FAIL mid_resp_fields got=%0h exp=0", {core_from_peripheral, core_from_peripheral_data}); end
      checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL mid_idle got=%0d exp=0", dbg_state); end
   endtask

`ifdef ARB_TIMEOUT_EN
   task automatic test_timeout();
      int   n;
      logic found;
      apply_reset();
      periph_req_ready = 1'b1;
      drive_req(3, 2'b10, 32'h30);
      step();
      clear_reqs();
      step();
      step();
      n = 0;
      found = 1'b0;
      while (n < 20 && !found) begin
         step();
         n++;
         if (core_from_peripheral_valid != 4'h0) found = 1'b1;
      end
      checks++; if (found !== 1'b1) begin failures++; $display("FAIL to_no_pulse got=%0d exp=1", found); end
      checks++; if (n !== TO) begin failures++; $display("FAIL to_latency got=%0d exp=%0d", n, TO); end
      checks++; if (core_from_peripheral_valid !== 4'b1000) begin failures++; $display("FAIL to_valid got=%0h exp=8", core_from_peripheral_valid); end
      checks++; if (core_from_peripheral_data[DW*3 +: DW] !== 32'hDEADBEEF) begin failures++; $display("FAIL to_data got=%0h exp=deadbeef", core_from_peripheral_data[DW*3 +: DW]); end
      checks++; if (core_from_peripheral[7:6] !== 2'b10) begin failures++; $display("FAIL to_cmd got=%0b exp=10", core_from_peripheral[7:6]); end
      checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL to_err got=%0h exp=1", timeout_err); end
      step();
      checks++; if ({core_from_peripheral_valid, dbg_state, timeout_err} !== {4'h0, 2'd0, 1'b1}) begin failures++; $display("FAIL to_after got=%0h exp=%0h", {core_from_peripheral_valid, dbg_state, timeout_err}, {4'h0, 2'd0, 1'b1}); end
   endtask
`else
   task automatic test_timeout();
      int pulses;
      apply_reset();
      periph_req_ready = 1'b1;
      drive_req(3, 2'b10, 32'h30);
      step();
      clear_reqs();
      step();
      step();
      pulses = 0;
      for (int k = 0; k < 3 * TO; k++) begin
         step();
         if (core_from_peripheral_valid != 4'h0) pulses++;
      end
      checks++; if (pulses !== 0) begin failures++; $display("FAIL nto_pulse got=%0d exp=0", pulses); end
      checks++; if ({dbg_state, timeout_err} !== {2'd2, 1'b0}) begin failures++; $display("FAIL nto_still_wait got=%0h exp=%0h", {dbg_state, timeout_err}, {2'd2, 1'b0}); end
      periph_resp_valid = 1'b1;
      periph_resp_data  = 32'h77;
      step();
      periph_resp_valid = 1'b0;
      checks++; if ({core_from_peripheral_valid, core_from_peripheral_data[DW*3 +: DW]} !== {4'b1000, 32'h77}) begin failures++; $display("FAIL nto_late_resp got=%0h exp=%0h", {core_from_peripheral_valid, core_from_peripheral_data[DW*3 +: DW]}, {4'b1000, 32'h77}); end
   endtask
`endif

   // Model: each core owns at most one outstanding request; the bus must issue
   // exactly those, and each accepted read must come back once to its core.
   task automatic test_random();
      logic              out_v   [NC];
      logic [1:0]        out_cmd [NC];
      logic [DW-1:0]     out_data[NC];
      logic              read_wait, just_acc, resp_expected, r;
      logic              prev_valid, prev_ready;
      logic [IB+2+DW-1:0] prev_req;
      logic [IB-1:0]     rd_id;
      logic [1:0]        rd_cmd, c;
      logic [DW-1:0]     rd_data;
      int                cd, cyc, issued, completed;
      logic              busy;
      apply_reset();
      for (int i = 0; i < NC; i++) out_v[i] = 1'b0;
      read_wait = 0; resp_expected = 0; prev_valid = 0; prev_ready = 0; prev_req = '0;
      rd_id = '0; rd_cmd = '0; rd_data = '0;
      cd = 0; cyc = 0; issued = 0; completed = 0;
      busy = 1'b1;
      while (busy && cyc < 4000) begin
         if (resp_expected) begin
            checks++; if ({core_from_peripheral_valid, core_from_peripheral[2*rd_id +: 2], core_from_peripheral_data[DW*rd_id +: DW]} !== {NC'(1) << rd_id, rd_cmd, rd_data}) begin failures++; $display("FAIL rnd_resp got=%0h exp=%0h", {core_from_peripheral_valid, core_from_peripheral[2*rd_id +: 2], core_from_peripheral_data[DW*rd_id +: DW]}, {NC'(1) << rd_id, rd_cmd, rd_data}); end
            resp_expected = 0;
            completed++;
         end else begin
            checks++; if (core_from_peripheral_valid !== 4'h0) begin failures++; $display("FAIL rnd_spurious_resp got=%0h exp=0", core_from_peripheral_valid); end
         end
         if (prev_valid && !prev_ready) begin
            checks++; if ({periph_req_valid, periph_req_id, periph_req_cmd, periph_req_data} !== {1'b1, prev_req}) begin failures++; $display("FAIL rnd_hold got=%0h exp=%0h", {periph_req_valid, periph_req_id, periph_req_cmd, periph_req_data}, {1'b1, prev_req}); end
         end
         r = ($urandom_range(0, 2) != 0);
         periph_req_ready = r;
         just_acc = 1'b0;
         if (periph_req_valid && r) begin
            checks++; if ({out_v[periph_req_id], periph_req_cmd, periph_req_data} !== {1'b1, out_cmd[periph_req_id], out_data[periph_req_id]}) begin failures++; $display("FAIL rnd_grant id=%0d got=%0h exp=%0h", periph_req_id, {out_v[periph_req_id], periph_req_cmd, periph_req_data}, {1'b1, out_cmd[periph_req_id], out_data[periph_req_id]}); end
            out_v[periph_req_id] = 1'b0;
            issued++;
            if (periph_req_cmd[1]) begin
               read_wait = 1'b1;
               just_acc  = 1'b1;
               rd_id     = periph_req_id;
               rd_cmd    = periph_req_cmd;
               cd        = $urandom_range(1, 4);
            end
         end
         prev_valid = periph_req_valid;
         prev_ready = r;
         prev_req   = {periph_req_id, periph_req_cmd, periph_req_data};
         periph_resp_valid = 1'b0;
         periph_resp_data  = $urandom;
         if (read_wait && !just_acc) begin
            cd--;
            if (cd == 0) begin
               periph_resp_valid = 1'b1;
               rd_data   = periph_resp_data;
               read_wait = 1'b0;
               resp_expected = 1'b1;
            end
         end else if (!read_wait && $urandom_range(0, 9) == 0) begin
            periph_resp_valid = 1'b1;
         end
         clear_reqs();
         if (cyc < 1500) begin
            for (int i = 0; i < NC; i++) begin
               if (!out_v[i] && $urandom_range(0, 3) == 0) begin
                  c = 2'($urandom_range(1, 3));
                  drive_req(i, c, $urandom);
                  out_v[i]    = 1'b1;
                  out_cmd[i]  = c;
                  out_data[i] = core_to_peripheral_data[DW*i +: DW];
               end else if ($urandom_range(0, 15) == 0) begin
                  drive_req(i, 2'b00, $urandom);
               end
            end
         end
         step();
         cyc++;
         busy = (cyc < 1500) || read_wait || resp_expected;
         for (int i = 0; i < NC; i++) if (out_v[i]) busy = 1'b1;
      end
      clear_reqs();
      periph_resp_valid = 1'b0;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rnd_drain got=busy exp=idle after %0d cycles", cyc); end
      checks++; if (overflow !== 4'h0) begin failures++; $display("FAIL rnd_overflow got=%0h exp=0", overflow); end
      checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL rnd_timeout_err got=%0h exp=0", timeout_err); end
      checks++; if (issued < 100) begin failures++; $display("FAIL rnd_activity got=%0d exp>=100", issued); end
      checks++; if (completed < 1) begin failures++; $display("FAIL rnd_reads got=%0d exp>=1", completed); end
   endtask

   initial begin
      reset                    = 1'b1;
      core_to_peripheral       = '0;
      core_to_peripheral_data  = '0;
      core_to_peripheral_valid = '0;
      periph_req_ready         = 1'b0;
      periph_resp_valid        = 1'b0;
      periph_resp_data         = '0;
      test_reset();
      test_single_write();
      test_single_read();
      test_round_robin();
      test_overflow();
      test_reset_mid_read();
      test_timeout();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/peripheral_arbiter.md
Name: peripheral_arbiter

Overview:
- Shares one peripheral bus (UART/GPIO-style device port) between NUM_CORES RISC_V_Core instances in the multi-core BRISC-V build.
- Captures each core's to_peripheral request into a per-core one-entry slot and grants the bus round-robin.
- Issues one transaction at a time and routes read responses back on the issuing core's from_peripheral channel.
- Sits between the cores' peripheral ports and the shared peripheral.

Parameters:
- NUM_CORES, 4, number of requesting cores (2..16).
- DATA_WIDTH, 32, peripheral data width.
- ID_BITS, 2, width of core index; must satisfy 2^ID_BITS >= NUM_CORES.
- TIMEOUT_CYCLES, 256, read-response watchdog limit; used only with ARB_TIMEOUT_EN.

Ports:
- clock  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- core_to_peripheral  input  2*NUM_CORES  per-core command; bit 1 = read, bit 0 = write. Core i occupies bits [2i+1:2i].
- core_to_peripheral_data  input  DATA_WIDTH*NUM_CORES  per-core write data or address.
- core_to_peripheral_valid  input  NUM_CORES  per-core request strobe; one-cycle pulse.
- core_from_peripheral  output  2*NUM_CORES  per-core response command echo.
- core_from_peripheral_data  output  DATA_WIDTH*NUM_CORES  per-core read data.
- core_from_peripheral_valid  output  NUM_CORES  per-core response pulse.
- periph_req_valid  output  1  request to shared peripheral.
- periph_req_cmd  output  2  granted command.
- periph_req_data  output  DATA_WIDTH  granted data.
- periph_req_id  output  ID_BITS  granted core index.
- periph_req_ready  input  1  peripheral accepts the request.
- periph_resp_valid  input  1  read response strobe.
- periph_resp_data  input  DATA_WIDTH  read response data.
- overflow  output  NUM_CORES  sticky per-core flag: request dropped.
- timeout_err  output  1  sticky watchdog flag; constant 0 without ARB_TIMEOUT_EN.

Behaviour:
- Reset: clears all slots, overflow, timeout_err and every valid output. All data and cmd outputs reset to 0. The round-robin pointer resets to 0. Reset mid-transaction abandons it; a periph_resp_valid arriving afterwards in IDLE is ignored.
- Slot capture: core i's valid with slot i empty stores cmd and data and sets pending[i] on the next edge.
- Slot full: valid with pending[i] set drops the new request and sets overflow[i]. The existing entry is unchanged.
- Command 2'b00: valid with cmd 2'b00 is ignored and no slot is written.
- Command 2'b11: treated as read.
- FSM IDLE: if any pending bit is set, select the first pending index at or after rr_ptr, cyclically. Load the periph_req_* registers, set periph_req_valid and go to ISSUE. This is one cycle after capture, so the earliest bus request is 2 cycles after the core strobe.
- FSM ISSUE: hold periph_req_* stable until periph_req_ready=1 at a clock edge. On that edge:
  - clear pending[grant] and set rr_ptr = grant+1, wrapping at NUM_CORES-1 -> 0;
  - drop periph_req_valid;
  - go to WAIT_RESP if cmd[1]=1, else go to IDLE (write is posted, no response to core).
- FSM WAIT_RESP: on periph_resp_valid, drive core_from_peripheral_valid[grant]=1 for exactly one cycle, with data = periph_resp_data and cmd echo = granted cmd. Return to IDLE.
- Response in other states: periph_resp_valid outside WAIT_RESP is ignored.
- Slot reuse: a core's slot is writable again in the same cycle it is cleared. A new valid on the grant edge is captured, not flagged.
- Concurrent capture: capture of other cores runs in parallel with every FSM state.
- Throughput: at most one transaction outstanding. Back-to-back writes with ready held high take 2 cycles each (IDLE, ISSUE).
- Response outputs: core_from_peripheral_data and cmd for a core hold their last value between pulses.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined: a counter runs in WAIT_RESP. Reaching TIMEOUT_CYCLES without periph_resp_valid completes the read as follows:
  - core_from_peripheral_valid[grant] pulses for one cycle;
  - data = 32'hDEAD_BEEF (lower DATA_WIDTH bits);
  - timeout_err is set (sticky until reset);
  - FSM returns to IDLE.
- Not defined: WAIT_RESP waits indefinitely, no counter logic exists, and timeout_err is tied to 0.

Test Plan:
- Single write: core 1 writes cmd 01, data 0x55. Expect periph_req_valid 2 cycles later with id=1, data 0x55. With ready=1, no core response and FSM back in IDLE.
- Single read: core 2 reads cmd 10, addr 0x10. Peripheral answers 0xCAFE0001 three cycles after accept. Expect core_from_peripheral_valid[2] for one cycle with data 0xCAFE0001 and cmd echo 10.
- Round-robin: cores 0-3 each write in the same cycle, ready always 1. Expect grant order 0,1,2,3, then a fresh request from core 0 is granted after core 3.
- Overflow: core 0 issues two writes on consecutive cycles while ready=0. Expect overflow[0]=1, only the first data issued, slot accepting again after the grant.
- Reset mid-read: assert reset in WAIT_RESP, then pulse periph_resp_valid. Expect no core response, all outputs 0 and rr_ptr=0.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8: read with no response. Expect a 0xDEADBEEF response after 8 WAIT_RESP cycles and timeout_err=1.
